id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline register and operand-select stage that sits directly upstream of the ALU. It captures decoded operands and control on each accepted clock edge and applies EX/MEM and MEM/WB result forwarding. It selects immediate or PC operands and drives `ALUctrl`, `ALUop1` and `ALUop2`. It also detects load-use hazards, and supports stall (hold) and flush (bubble insertion) from the hazard/branch logic.

## Interface
- `D_WIDTH`, 32, datapath width
- `A_WIDTH`, 5, register-address width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold all stage registers
- `flush`  in  1  load a bubble on next edge
- `id_valid`  in  1  decode slot holds a real instruction
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  A_WIDTH  register addresses
- `id_rs1_data`, `id_rs2_data`  in  D_WIDTH  register-file read data
- `id_imm`, `id_pc`  in  D_WIDTH  sign-extended immediate, instruction PC
- `id_alu_ctrl`  in  3  ALU operation code (000 add … 111 srl)
- `id_op1_pc`  in  1  op1 = PC instead of rs1
- `id_op2_imm`  in  1  op2 = imm instead of rs2
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  downstream control
- `exmem_rd`, `memwb_rd`  in  A_WIDTH  destination of older instructions
- `exmem_reg_write`, `memwb_reg_write`  in  1  those instructions write back
- `exmem_result`, `memwb_result`  in  D_WIDTH  their results
- `ALUctrl`  out  3  to ALU
- `ALUop1`, `ALUop2`  out  D_WIDTH  to ALU
- `ex_store_data`  out  D_WIDTH  forwarded rs2 for stores
- `ex_rd`  out  A_WIDTH
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1
- `ex_pc`  out  D_WIDTH
- `load_use_hazard`  out  1  request to stall decode/fetch

## Operation
- Stage registers: valid, rs1/rs2 addr+data, rd, imm, pc, alu_ctrl, op1_pc, op2_imm, reg_write, mem_read, mem_write.
- Per edge, priority rst > flush > stall > load:
  - flush: valid, reg_write, mem_read and mem_write are set to 0; alu_ctrl is set to 000; all other fields are don't-care but are zeroed.
  - stall: all registers hold.
  - load: capture all `id_*`. Control bits are ANDed with `id_valid`.
- Forwarding, combinational on registered rs addresses, per source operand:
  - First choice is EX/MEM if `exmem_reg_write` and `exmem_rd != 0` and `exmem_rd == rs`.
  - Otherwise MEM/WB under the same conditions.
  - Otherwise the registered data.
  - EX/MEM has priority over MEM/WB. Register x0 is never forwarded.
- `ALUop1` = `op1_pc` ? pc : fwd_rs1. `ALUop2` = `op2_imm` ? imm : fwd_rs2. `ex_store_data` = fwd_rs2 always.
- `ALUctrl` = registered alu_ctrl.
- `load_use_hazard` = `ex_valid & ex_mem_read & ex_rd != 0 & (ex_rd == id_rs1_addr | ex_rd == id_rs2_addr) & id_valid`. It is combinational.
- The block does not self-stall. The hazard unit returns `flush` (bubble into EX) and stalls IF/ID. `stall` is not asserted to this block for load-use.
- No arithmetic in this block. All widths pass through unmodified.

## Timing
- Latency: `id_*` sampled at edge N appear on the `ex_*`, `ALUctrl` and `ALUop*` outputs after edge N.
- Forwarding paths are same-cycle combinational: a change on `exmem_result` changes `ALUop*` without a clock.
- Reset (asynchronous, immediate): all registers are 0. `ALUctrl` = 000 and `ex_valid`/`ex_reg_write`/`ex_mem_read`/`ex_mem_write` = 0. `ex_rd` = 0 and `ex_pc` = 0. `ALUop1`/`ALUop2`/`ex_store_data` = 0 unless forwarding matches rs=0, which it cannot. `load_use_hazard` = 0.
- Reset deassertion mid-stream: the first edge after release loads normally.
- Simultaneous `flush` and `stall`: flush wins.
- Sustained `stall`: the outputs are stable except for combinational forwarding updates.

## Test plan
- Reset: assert `rst` mid-cycle with valid contents loaded. Required: all outputs 0 immediately, before the next edge.
- Pass-through: load rs1_data=5, rs2_data=7, alu_ctrl=001, op2_imm=0. Required after one edge: ALUop1=5, ALUop2=7, ALUctrl=001.
- Forward priority: EX rs1=3; exmem_rd=3 with result 0xAAAA; memwb_rd=3 with result 0xBBBB; both write. Required: ALUop1=0xAAAA. With exmem_reg_write=0, required: ALUop1=0xBBBB.
- x0 guard: rs2=0, exmem_rd=0, exmem_reg_write=1, result 0xFFFF, op2_imm=0. Required: ALUop2 = registered rs2_data (0).
- Load-use: EX holds mem_read with rd=4; decode id_rs2_addr=4, id_valid=1. Required: load_use_hazard=1. Then apply flush for one edge. Required: ex_valid=0, ex_reg_write=0, ALUctrl=000.
- Stall/flush: stall=1 for 3 edges while id_* changes. Required: outputs hold. Then stall=1 and flush=1 together. Required: a bubble is loaded.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register and ALU operand select. Captures the
// decoded instruction on each accepted edge, forwards EX/MEM and MEM/WB
// results onto the registered source operands, selects PC/immediate operands
// and flags load-use hazards for the upstream hazard unit.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   stall, flush             hold stage / load a bubble (flush wins)
//   id_*                     decoded instruction from the ID stage
//   exmem_*, memwb_*         destination, write-enable and result of the two
//                            older in-flight instructions (forwarding sources)
//   ALUctrl, ALUop1, ALUop2  ALU operation and operands
//   ex_store_data            forwarded rs2, used as store data
//   ex_rd, ex_pc, ex_valid,
//   ex_reg_write,
//   ex_mem_read,
//   ex_mem_write             registered instruction info for later stages
//   load_use_hazard          combinational request to stall IF/ID
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [A_WIDTH-1:0] id_rs1_addr,
   input  logic [A_WIDTH-1:0] id_rs2_addr,
   input  logic [A_WIDTH-1:0] id_rd_addr,
   input  logic [D_WIDTH-1:0] id_rs1_data,
   input  logic [D_WIDTH-1:0] id_rs2_data,
   input  logic [D_WIDTH-1:0] id_imm,
   input  logic [D_WIDTH-1:0] id_pc,
   input  logic [2:0]         id_alu_ctrl,
   input  logic               id_op1_pc,
   input  logic               id_op2_imm,
   input  logic               id_reg_write,
   input  logic               id_mem_read,
   input  logic               id_mem_write,
   input  logic [A_WIDTH-1:0] exmem_rd,
   input  logic [A_WIDTH-1:0] memwb_rd,
   input  logic               exmem_reg_write,
   input  logic               memwb_reg_write,
   input  logic [D_WIDTH-1:0] exmem_result,
   input  logic [D_WIDTH-1:0] memwb_result,
   output logic [2:0]         ALUctrl,
   output logic [D_WIDTH-1:0] ALUop1,
   output logic [D_WIDTH-1:0] ALUop2,
   output logic [D_WIDTH-1:0] ex_store_data,
   output logic [A_WIDTH-1:0] ex_rd,
   output logic               ex_valid,
   output logic               ex_reg_write,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic [D_WIDTH-1:0] ex_pc,
   output logic               load_use_hazard
);

   logic               valid_q,     valid_d;
   logic [A_WIDTH-1:0] rs1_addr_q,  rs1_addr_d;
   logic [A_WIDTH-1:0] rs2_addr_q,  rs2_addr_d;
   logic [A_WIDTH-1:0] rd_q,        rd_d;
   logic [D_WIDTH-1:0] rs1_data_q,  rs1_data_d;
   logic [D_WIDTH-1:0] rs2_data_q,  rs2_data_d;
   logic [D_WIDTH-1:0] imm_q,       imm_d;
   logic [D_WIDTH-1:0] pc_q,        pc_d;
   logic [2:0]         alu_ctrl_q,  alu_ctrl_d;
   logic               op1_pc_q,    op1_pc_d;
   logic               op2_imm_q,   op2_imm_d;
   logic               reg_write_q, reg_write_d;
   logic               mem_read_q,  mem_read_d;
   logic               mem_write_q, mem_write_d;

   logic [D_WIDTH-1:0] fwd_rs1;
   logic [D_WIDTH-1:0] fwd_rs2;

   // Next-state: flush beats stall; a held stage keeps every field.
   always_comb begin
      valid_d     = valid_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rd_d        = rd_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      pc_d        = pc_q;
      alu_ctrl_d  = alu_ctrl_q;
      op1_pc_d    = op1_pc_q;
      op2_imm_d   = op2_imm_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      if (flush) begin
         // Bubble: everything zeroed so a flushed slot looks like reset.
         valid_d     = 1'b0;
         rs1_addr_d  = '0;
         rs2_addr_d  = '0;
         rd_d        = '0;
         rs1_data_d  = '0;
         rs2_data_d  = '0;
         imm_d       = '0;
         pc_d        = '0;
         alu_ctrl_d  = 3'b000;
         op1_pc_d    = 1'b0;
         op2_imm_d   = 1'b0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
      end else if (!stall) begin
         valid_d     = id_valid;
         rs1_addr_d  = id_rs1_addr;
         rs2_addr_d  = id_rs2_addr;
         rd_d        = id_rd_addr;
         rs1_data_d  = id_rs1_data;
         rs2_data_d  = id_rs2_data;
         imm_d       = id_imm;
         pc_d        = id_pc;
         alu_ctrl_d  = id_alu_ctrl;
         op1_pc_d    = id_op1_pc;
         op2_imm_d   = id_op2_imm;
         // An empty decode slot must never write back or touch memory.
         reg_write_d = id_reg_write & id_valid;
         mem_read_d  = id_mem_read  & id_valid;
         mem_write_d = id_mem_write & id_valid;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= 1'b0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rd_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         pc_q        <= '0;
         alu_ctrl_q  <= 3'b000;
         op1_pc_q    <= 1'b0;
         op2_imm_q   <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rd_q        <= rd_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         pc_q        <= pc_d;
         alu_ctrl_q  <= alu_ctrl_d;
         op1_pc_q    <= op1_pc_d;
         op2_imm_q   <= op2_imm_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

   // Forwarding: the younger EX/MEM result shadows MEM/WB; x0 is never
   // forwarded since it reads as constant zero.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_addr_q)) begin
         fwd_rs1 = exmem_result;
      end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_addr_q)) begin
         fwd_rs1 = memwb_result;
      end
   end

   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_addr_q)) begin
         fwd_rs2 = exmem_result;
      end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_addr_q)) begin
         fwd_rs2 = memwb_result;
      end
   end

   assign ALUctrl       = alu_ctrl_q;
   assign ALUop1        = op1_pc_q  ? pc_q  : fwd_rs1;
   assign ALUop2        = op2_imm_q ? imm_q : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign ex_rd         = rd_q;
   assign ex_valid      = valid_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_mem_write  = mem_write_q;
   assign ex_pc         = pc_q;

   // A load in EX cannot forward its data in time to a dependent instruction
   // sitting in decode; the hazard unit answers with flush + IF/ID stall.
   assign load_use_hazard = valid_q & mem_read_q & (rd_q != '0) &
                            ((rd_q == id_rs1_addr) | (rd_q == id_rs2_addr)) & id_valid;

endmodule
